// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR addresses, op encodings, cause codes and mstatus bit positions
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MSTATUSH      = 12'h310;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [4:0] IRQ_CAUSE_MSI = 5'd3;
  localparam logic [4:0] IRQ_CAUSE_MTI = 5'd7;
  localparam logic [4:0] IRQ_CAUSE_MEI = 5'd11;
  localparam int IRQ_LOCAL_BASE = 16;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  // Addresses 0xC00-0xFFF are read-only by encoding; misa is read-only here too.
  function automatic logic csr_is_ro(input logic [11:0] adr);
    return (adr[11:10] == 2'b11) || (adr == CSR_MISA);
  endfunction

endpackage

// File: rtl/csr_irq_arb.sv
// rtl/csr_irq_arb.sv - fixed-priority interrupt arbiter: MEI > MSI > MTI > local (highest index first)
module csr_irq_arb
  import csr_pkg::*;
#(
  parameter int NUM_LOCAL_IRQ = 4
) (
  input  logic                     i_gie,
  input  logic                     i_mei,
  input  logic                     i_msi,
  input  logic                     i_mti,
  input  logic [NUM_LOCAL_IRQ-1:0] i_local,
  output logic                     o_irq_req,
  output logic [4:0]               o_irq_cause
);

  // Later assignments override earlier ones, so lowest priority is evaluated first.
  always_comb begin
    o_irq_cause = '0;
    for (int i = 0; i < NUM_LOCAL_IRQ; i++) begin
      if (i_local[i]) o_irq_cause = 5'(IRQ_LOCAL_BASE + i);
    end
    if (i_mti) o_irq_cause = IRQ_CAUSE_MTI;
    if (i_msi) o_irq_cause = IRQ_CAUSE_MSI;
    if (i_mei) o_irq_cause = IRQ_CAUSE_MEI;
  end

  assign o_irq_req = i_gie && (i_mei || i_msi || i_mti || (|i_local));

endmodule

// File: rtl/csr_unit_mx.sv
// rtl/csr_unit_mx.sv - machine-mode CSR unit: Zicsr ops, trap stacking, counters, irq/vector logic
module csr_unit_mx
  import csr_pkg::*;
#(
  parameter int          NUM_LOCAL_IRQ = 4,
  parameter int          CNT_WIDTH     = 64,
  parameter bit          VECTORED_EN   = 1'b1,
  parameter logic [31:0] MISA_VALUE    = 32'h4000_0100,
  parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_csr_valid,
  input  logic [11:0]              i_csr_adr,
  input  logic [2:0]               i_csr_op,
  input  logic [4:0]               i_csr_uimm,
  input  logic [31:0]              i_csr_wsrc,
  output logic [31:0]              o_csr_rdata,
  output logic                     o_csr_illegal,
  input  logic                     i_exc_take,
  input  logic [3:0]               i_exc_cause,
  input  logic [31:0]              i_exc_tval,
  input  logic                     i_irq_take,
  input  logic [29:0]              i_trap_pc,
  input  logic                     i_mret,
  input  logic                     i_instret,
  input  logic                     i_ext_irq,
  input  logic                     i_sw_irq,
  input  logic                     i_tmr_irq,
  input  logic [NUM_LOCAL_IRQ-1:0] i_local_irq,
  output logic                     o_irq_req,
  output logic [4:0]               o_irq_cause,
  output logic [29:0]              o_trap_vector,
  output logic [29:0]              o_mepc_out
);

  localparam logic [31:0] MIE_MASK =
    32'h0000_0888 | 32'(((64'd1 << NUM_LOCAL_IRQ) - 64'd1) << IRQ_LOCAL_BASE);

  logic                 r_mstatus_mie, r_mstatus_mpie;
  logic [31:0]          r_mie, r_mtvec, r_mscratch, r_mcause, r_mtval, r_rdata;
  logic [29:0]          r_mepc;
  logic                 r_cy, r_ir;
  logic [CNT_WIDTH-1:0] r_mcycle, r_minstret;

  logic [31:0] w_mip, w_old, w_src, w_wdata;
  logic        w_known, w_wr, w_ill, w_we;
  csr_op_e     w_op;

  always_comb begin
    w_mip = '0;
    w_mip[11] = i_ext_irq;
    w_mip[7]  = i_tmr_irq;
    w_mip[3]  = i_sw_irq;
    w_mip[IRQ_LOCAL_BASE +: NUM_LOCAL_IRQ] = i_local_irq;
  end

  always_comb begin
    w_old   = '0;
    w_known = 1'b1;
    case (i_csr_adr)
      CSR_MSTATUS: begin
        w_old[12:11]        = 2'b11;
        w_old[MSTATUS_MPIE] = r_mstatus_mpie;
        w_old[MSTATUS_MIE]  = r_mstatus_mie;
      end
      CSR_MISA:                  w_old = MISA_VALUE;
      CSR_MIE:                   w_old = r_mie;
      CSR_MTVEC:                 w_old = r_mtvec;
      CSR_MSTATUSH, CSR_MHARTID: w_old = '0;
      CSR_MCOUNTINHIBIT: begin
        w_old[0] = r_cy;
        w_old[2] = r_ir;
      end
      CSR_MSCRATCH:                w_old = r_mscratch;
      CSR_MEPC:                    w_old = {r_mepc, 2'b00};
      CSR_MCAUSE:                  w_old = r_mcause;
      CSR_MTVAL:                   w_old = r_mtval;
      CSR_MIP:                     w_old = w_mip;
      CSR_MCYCLE, CSR_CYCLE:       w_old = r_mcycle[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:     w_old = 32'(r_mcycle[CNT_WIDTH-1:32]);
      CSR_MINSTRET, CSR_INSTRET:   w_old = r_minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: w_old = 32'(r_minstret[CNT_WIDTH-1:32]);
      default:                     w_known = 1'b0;
    endcase
  end

  assign w_op  = csr_op_e'(i_csr_op[1:0]);
  assign w_src = i_csr_op[2] ? {27'b0, i_csr_uimm} : i_csr_wsrc;

  always_comb begin
    case (w_op)
      CSR_OP_RS: w_wdata = w_old | w_src;
      CSR_OP_RC: w_wdata = w_old & ~w_src;
      default:   w_wdata = w_src;
    endcase
  end

  // Set/clear with a zero source is a pure read, so it may target read-only CSRs.
  assign w_wr  = i_csr_valid && ((w_op == CSR_OP_RW) || ((w_op != CSR_OP_NONE) && (w_src != '0)));
  assign w_ill = i_csr_valid && (!w_known || (w_wr && csr_is_ro(i_csr_adr)));
  assign w_we  = w_wr && !w_ill && !i_exc_take && !i_irq_take && !i_mret;

  assign o_csr_illegal = w_ill;
  assign o_csr_rdata   = r_rdata;
  assign o_mepc_out    = r_mepc;

  csr_irq_arb #(.NUM_LOCAL_IRQ(NUM_LOCAL_IRQ)) u_irq_arb (
    .i_gie       (r_mstatus_mie),
    .i_mei       (i_ext_irq & r_mie[11]),
    .i_msi       (i_sw_irq & r_mie[3]),
    .i_mti       (i_tmr_irq & r_mie[7]),
    .i_local     (i_local_irq & r_mie[IRQ_LOCAL_BASE +: NUM_LOCAL_IRQ]),
    .o_irq_req   (o_irq_req),
    .o_irq_cause (o_irq_cause)
  );

  assign o_trap_vector = (!i_exc_take && (r_mtvec[1:0] == 2'b01))
                       ? r_mtvec[31:2] + 30'(o_irq_cause) : r_mtvec[31:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mtvec        <= MTVEC_RESET;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
      r_cy           <= 1'b0;
      r_ir           <= 1'b0;
      r_rdata        <= '0;
    end else begin
      if (i_csr_valid) r_rdata <= w_old;
      if (i_exc_take || i_irq_take) begin
        r_mepc         <= i_trap_pc;
        r_mcause       <= i_exc_take ? {28'b0, i_exc_cause} : {1'b1, 26'b0, o_irq_cause};
        r_mtval        <= i_exc_take ? i_exc_tval : '0;
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (i_mret) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end else if (w_we) begin
        case (i_csr_adr)
          CSR_MSTATUS: begin
            r_mstatus_mie  <= w_wdata[MSTATUS_MIE];
            r_mstatus_mpie <= w_wdata[MSTATUS_MPIE];
          end
          CSR_MIE:   r_mie <= w_wdata & MIE_MASK;
          CSR_MTVEC: r_mtvec <= {w_wdata[31:2],
                                 (VECTORED_EN && (w_wdata[1:0] == 2'b01)) ? 2'b01 : 2'b00};
          CSR_MCOUNTINHIBIT: begin
            r_cy <= w_wdata[0];
            r_ir <= w_wdata[2];
          end
          CSR_MSCRATCH: r_mscratch <= w_wdata;
          CSR_MEPC:     r_mepc <= w_wdata[31:2];
          CSR_MCAUSE:   r_mcause <= w_wdata;
          CSR_MTVAL:    r_mtval <= w_wdata;
          default: ;
        endcase
      end
    end
  end

  // A write to either half of a counter suppresses that counter's increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      if (w_we && (i_csr_adr == CSR_MCYCLE))
        r_mcycle[31:0] <= w_wdata;
      else if (w_we && (i_csr_adr == CSR_MCYCLEH))
        r_mcycle[CNT_WIDTH-1:32] <= w_wdata[CNT_WIDTH-33:0];
      else if (!r_cy)
        r_mcycle <= r_mcycle + CNT_WIDTH'(1);

      if (w_we && (i_csr_adr == CSR_MINSTRET))
        r_minstret[31:0] <= w_wdata;
      else if (w_we && (i_csr_adr == CSR_MINSTRETH))
        r_minstret[CNT_WIDTH-1:32] <= w_wdata[CNT_WIDTH-33:0];
      else if (i_instret && !r_ir)
        r_minstret <= r_minstret + CNT_WIDTH'(1);
    end
  end

endmodule
